mips_bus_arbiter: RTL

- Shares the single Avalon memory-mapped bus between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Sits between the CPU's fetch and memory sequencing logic and the external bus master interface.
- Grants the bus to one port per transaction and forwards that port's signals unchanged.
- Stalls the losing port with waitrequest.

---
 rtl/mips_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//   Shares one Avalon-MM bus master interface between instruction fetch
//   (port 0) and data load/store (port 1). One port owns the bus per
//   transaction; its signals pass straight through to the bus, and the
//   other port is held off with waitrequest.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   p0_* / p1_*         requester-side Avalon slave ports (address, read,
//                       write, writedata, byteenable in; waitrequest,
//                       readdata out)
//   address .. readdata bus-side Avalon master port
//   grant               one-hot owner: 01 = port 0, 10 = port 1, 00 = idle
//
// Configuration
//   ARB_FIXED_PRIORITY_EN  when defined, port 0 always wins a tie;
//                          otherwise ties alternate (round robin).
module mips_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   p0_address,
  input  logic                    p0_read,
  input  logic                    p0_write,
  input  logic [DATA_WIDTH-1:0]   p0_writedata,
  input  logic [DATA_WIDTH/8-1:0] p0_byteenable,
  output logic                    p0_waitrequest,
  output logic [DATA_WIDTH-1:0]   p0_readdata,
  input  logic [ADDR_WIDTH-1:0]   p1_address,
  input  logic                    p1_read,
  input  logic                    p1_write,
  input  logic [DATA_WIDTH-1:0]   p1_writedata,
  input  logic [DATA_WIDTH/8-1:0] p1_byteenable,
  output logic                    p1_waitrequest,
  output logic [DATA_WIDTH-1:0]   p1_readdata,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    read,
  output logic                    write,
  output logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    waitrequest,
  input  logic [DATA_WIDTH-1:0]   readdata,
  output logic [1:0]              grant
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       req0;
  logic       req1;
  logic       tie_to_p0;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_to_p0 = 1'b1;
`else
  // last_winner: 0 = port 0 won last, 1 = port 1 won last.
  // Reset to 1 so port 0 takes the first tie.
  logic last_winner;
  assign tie_to_p0 = last_winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner <= 1'b1;
    end else if (state == GNT0 && req0 && !waitrequest) begin
      last_winner <= 1'b0;
    end else if (state == GNT1 && req1 && !waitrequest) begin
      last_winner <= 1'b1;
    end
  end
`endif

  // Every grant ends in IDLE, either on completion or on withdrawal, so
  // the other port gets a chance to win between transactions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || tie_to_p0)) state_nxt = GNT0;
        else if (req1)                    state_nxt = GNT1;
      end
      GNT0:    if (!req0 || !waitrequest) state_nxt = IDLE;
      GNT1:    if (!req1 || !waitrequest) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      state <= state_nxt;
      grant <= {state_nxt == GNT1, state_nxt == GNT0};
    end
  end

  // Bus mux. A simultaneous read+write is illegal and is forwarded as a
  // read only.
  always_comb begin
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    byteenable     = '0;
    p0_waitrequest = 1'b1;
    p1_waitrequest = 1'b1;
    case (state)
      GNT0: begin
        address        = p0_address;
        read           = p0_read;
        write          = p0_write & ~p0_read;
        writedata      = p0_writedata;
        byteenable     = p0_byteenable;
        p0_waitrequest = waitrequest;
      end
      GNT1: begin
        address        = p1_address;
        read           = p1_read;
        write          = p1_write & ~p1_read;
        writedata      = p1_writedata;
        byteenable     = p1_byteenable;
        p1_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  assign p0_readdata = readdata;
  assign p1_readdata = readdata;

endmodule
